keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised ROWS×COLS matrix keypad scanner with frame-based debounce, multi-key rejection and a ready/ack output handshake. It drives one-hot column strobes, samples the row inputs after a programmable settle time, and reports one debounced key index per press. It sits between the board keypad pins and the menu/control logic, and replaces the fixed 3×4 single-shot scanner with a continuous, parametrised one.

## Interface
- `ROWS`, default 4: number of row inputs.
- `COLS`, default 3: number of column strobes.
- `CLK_FREQ`, default 25000000: clk frequency in Hz.
- `POLL_FREQ`, default 10000: column step rate in Hz. `PERIOD = CLK_FREQ/POLL_FREQ` clocks per column; must be ≥ 2.
- `DEBOUNCE_FRAMES`, default 4: identical consecutive frames required to accept a press or a release; must be ≥ 1.
- `REPEAT_FRAMES`, default 200: hold time, in frames, before each auto-repeat (used only with `KEYPAD_REPEAT_EN`).
- Derived `KW = $clog2(ROWS*COLS)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `scan` in 1: level enable for continuous scanning.
- `row` in ROWS: row sense lines, active-high, already synchronised.
- `col` out COLS: one-hot column strobe, active-high; all zeros when idle.
- `key_code` out KW: accepted key index.
- `key_ready` out 1: key_code valid; held until acknowledged.
- `key_ack` in 1: consumer acknowledge; sampled only while key_ready=1.
- `multi_key` out 1: one-cycle pulse when a frame shows two or more keys pressed.
- `overrun` out 1: one-cycle pulse when a key is accepted while key_ready is still 1.

## Operation
- Reset values: col=0, key_code=0, key_ready=0, multi_key=0, overrun=0; FSM in IDLE; frame buffer, debounce counter and latched state all cleared.
- The FSM has three states: IDLE, STROBE and EVAL.
- IDLE:
  - col=0.
  - When scan=1, go to STROBE with col index c=COLS-1 (col[COLS-1]=1) and clear the settle counter.
- STROBE:
  - Drive col one-hot for PERIOD clocks.
  - On the last clock, capture row into frame bits [c*ROWS +: ROWS].
  - If c>0: decrement c, restart the counter and stay in STROBE.
  - If c=0: go to EVAL.
- EVAL (one clock, col=0):
  - Count set bits in the ROWS*COLS frame.
  - 0 set bits: candidate = NONE.
  - 1 set bit: candidate = index (r_from_top*COLS + c_from_left), where r_from_top = ROWS-1-r and c_from_left = COLS-1-c. For a 4×3 pad, top-left = 0 and bottom-right = 11.
  - ≥2 set bits: pulse multi_key and treat the candidate as INVALID, which resets the debounce counter.
  - Then go to STROBE (c=COLS-1) if scan=1, else IDLE.
- Debounce:
  - If the candidate equals the previous frame's candidate, the counter increments and saturates; otherwise the counter is set to 1.
  - When the counter reaches DEBOUNCE_FRAMES with a key index, and the accepted state is RELEASED, latch key_code, set key_ready=1 and move the accepted state to HELD.
  - When the counter reaches DEBOUNCE_FRAMES with NONE, the accepted state returns to RELEASED.
  - One press produces one report.
- Handshake:
  - A cycle with key_ready=1 and key_ack=1 clears key_ready on the next clock.
  - key_ack=0 leaves key_ready set indefinitely.
  - key_ack while key_ready=0 is ignored.
- Overrun: an acceptance while key_ready=1 pulses overrun. key_code and key_ready are left unchanged, so the first key is kept.
- Deassert scan mid-frame:
  - The current column finishes; the FSM then goes to IDLE without EVAL.
  - Frame buffer and debounce counter are cleared.
  - Accepted state returns to RELEASED.
  - key_ready and key_code are retained until acked.
- Reset mid-operation returns everything to the reset values on the next clock.

## Timing
- One frame takes COLS*PERIOD + 1 clocks.
- The first strobe is driven on the clock after scan is first seen high in IDLE.
- Press latency: key_ready rises on the clock after the EVAL of the DEBOUNCE_FRAMES-th matching frame. This is ≤ (DEBOUNCE_FRAMES+1) frames after the contacts close.
- key_code is stable whenever key_ready=1.
- multi_key and overrun rise on the clock after EVAL and last exactly one cycle.

## Configuration
- Macro: `KEYPAD_REPEAT_EN`.
- Defined:
  - While HELD with the same index, a frame counter runs.
  - Every REPEAT_FRAMES matching frames, the key is re-accepted: key_ready sets, or overrun pulses if key_ready is still set.
  - Release or a change of key resets the counter.
- Undefined: no repeat logic is synthesised; `REPEAT_FRAMES` is ignored; one report per press.

## Test plan
Bench parameters: ROWS=4, COLS=3, CLK_FREQ=1000, POLL_FREQ=100 (PERIOD=10), DEBOUNCE_FRAMES=2, REPEAT_FRAMES=3.
- **Idle and scan start:** scan=0 → col=0 and all outputs 0. scan=1 → col steps 100, 010, 001, each held 10 clocks; frame = 31 clocks.
- **Clean press:** hold row[3] during col[2] → key_code=0 and key_ready=1 after the 2nd EVAL. Ack → key_ready=0. No second report while held. Release, then press row[0] on col[0] → key_code=11.
- **Bounce and invalid frames:** toggle the key every other frame → no key_ready. Press two keys → multi_key pulse each frame and no key_ready.
- **Overrun:** accept key 4 and never ack, then release and press key 8 → overrun pulses once, key_code stays 4.
- **Mid-frame stop:** scan=0 during col[1] → col[1] completes its 10 clocks, then col=0 and the FSM is IDLE with no EVAL. Assert rst_n=0 mid-frame → all outputs 0 on the next clock.
- **Repeat build (`KEYPAD_REPEAT_EN`):** hold key 5, acking each report → key_ready re-asserts every 3 frames after the initial accept. Undefined build → a single report only.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column strobe, frame debounce, ready/ack report.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int CLK_FREQ        = 25000000,
    parameter int POLL_FREQ       = 10000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 200,
    localparam int KW             = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [KW-1:0]   key_code,
    output logic            key_ready,
    input  logic            key_ack,
    output logic            multi_key,
    output logic            overrun
);
    localparam int PERIOD = CLK_FREQ / POLL_FREQ;
    localparam int N      = ROWS * COLS;
    localparam int PW     = $clog2(PERIOD);
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [COLS-1:0] COL_FIRST = COLS'(1) << (COLS - 1);

    typedef enum logic [1:0] {IDLE, STROBE, EVAL} state_t;
    typedef enum logic [1:0] {C_NONE, C_KEY, C_INVALID} cand_t;

    state_t        state;
    logic [PW-1:0] cnt;
    logic [CW-1:0] cidx;
    logic [N-1:0]  frame;
    cand_t         prev_cand;
    logic [KW-1:0] prev_idx;
    logic [DW-1:0] db_cnt;
    logic          held;

    logic [1:0]    nbits;
    logic [KW-1:0] idx;
    cand_t         cand;
    logic          same;
    logic [DW-1:0] db_next;
    logic          rel_done;
    logic          accept;
    logic          rep_fire;

    // nbits saturates at 2: only none / one / several matters
    always_comb begin
        nbits = 2'd0;
        idx   = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (frame[c*ROWS + r]) begin
                    if (nbits != 2'd2) nbits = nbits + 2'd1;
                    idx = KW'((ROWS - 1 - r) * COLS + (COLS - 1 - c));
                end
            end
        end
    end

    always_comb begin
        cand = C_INVALID;
        if (nbits == 2'd0)
            cand = C_NONE;
        else if (nbits == 2'd1)
            cand = C_KEY;
        same = (cand == prev_cand) && (cand != C_KEY || idx == prev_idx);
        if (cand == C_INVALID)
            db_next = '0;
        else if (!same)
            db_next = DW'(1);
        else if (db_cnt == DW'(DEBOUNCE_FRAMES))
            db_next = db_cnt;
        else
            db_next = db_cnt + DW'(1);
        rel_done = (cand == C_NONE) && (db_next == DW'(DEBOUNCE_FRAMES));
        accept   = ((cand == C_KEY) && (db_next == DW'(DEBOUNCE_FRAMES)) && !held)
                   || rep_fire;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);

    logic [RW-1:0] rep_cnt;
    logic [KW-1:0] held_idx;
    logic          rep_match;

    assign rep_match = held && (cand == C_KEY) && (idx == held_idx);
    assign rep_fire  = rep_match && (rep_cnt == RW'(REPEAT_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt  <= '0;
            held_idx <= '0;
        end else if (state == STROBE && cnt == PW'(PERIOD - 1) && !scan) begin
            rep_cnt <= '0;
        end else if (state == EVAL) begin
            if (accept)
                held_idx <= idx;
            if (!rep_match || rep_fire)
                rep_cnt <= '0;
            else
                rep_cnt <= rep_cnt + RW'(1);
        end
    end
`else
    localparam int repeat_unused = REPEAT_FRAMES;
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cidx      <= '0;
            frame     <= '0;
            prev_cand <= C_NONE;
            prev_idx  <= '0;
            db_cnt    <= '0;
            held      <= 1'b0;
            col       <= '0;
            key_code  <= '0;
            key_ready <= 1'b0;
            multi_key <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            multi_key <= 1'b0;
            overrun   <= 1'b0;
            if (key_ready && key_ack)
                key_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scan) begin
                        state <= STROBE;
                        cidx  <= CW'(COLS - 1);
                        cnt   <= '0;
                        col   <= COL_FIRST;
                    end
                end
                STROBE: begin
                    if (cnt == PW'(PERIOD - 1)) begin
                        cnt <= '0;
                        if (!scan) begin
                            // partial frame is dropped and press history forgotten
                            state     <= IDLE;
                            col       <= '0;
                            frame     <= '0;
                            prev_cand <= C_NONE;
                            prev_idx  <= '0;
                            db_cnt    <= '0;
                            held      <= 1'b0;
                        end else begin
                            frame[cidx*ROWS +: ROWS] <= row;
                            if (cidx == '0) begin
                                state <= EVAL;
                                col   <= '0;
                            end else begin
                                cidx <= cidx - CW'(1);
                                col  <= col >> 1;
                            end
                        end
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                EVAL: begin
                    prev_cand <= cand;
                    prev_idx  <= idx;
                    db_cnt    <= db_next;
                    if (cand == C_INVALID)
                        multi_key <= 1'b1;
                    if (rel_done)
                        held <= 1'b0;
                    if (accept) begin
                        held <= 1'b1;
                        if (key_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            key_code  <= idx;
                            key_ready <= 1'b1;
                        end
                    end
                    if (scan) begin
                        state <= STROBE;
                        cidx  <= CW'(COLS - 1);
                        cnt   <= '0;
                        col   <= COL_FIRST;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model, frame-level reference, random + directed stimulus.
// Honours KEYPAD_REPEAT_EN in both the reference and the directed hold test.
module tb_keypad_scanner;
    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int PER   = 10;
    localparam int DF    = 2;
    localparam int RF    = 3;
    localparam int NK    = ROWS * COLS;
    localparam int FRAME = COLS * PER + 1;
    localparam int NONE  = -1;
    localparam int INV   = -2;

    logic            clk;
    logic            rst_n;
    logic            scan;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [3:0]      key_code;
    logic            key_ready;
    logic            key_ack;
    logic            multi_key;
    logic            overrun;
    logic [NK-1:0]   keys;

    int vectors = 0;
    int miscompares = 0;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .CLK_FREQ(1000), .POLL_FREQ(100),
        .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(RF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan(scan), .row(row), .col(col),
        .key_code(key_code), .key_ready(key_ready), .key_ack(key_ack),
        .multi_key(multi_key), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // physical pad: key k sits at row from top k/COLS, column from left k%COLS
    always_comb begin
        row = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (col[c] && keys[(ROWS - 1 - r) * COLS + (COLS - 1 - c)])
                    row[r] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit            m_run;
    int            m_pos;
    bit [NK-1:0]   m_mask;
    int            m_prev;
    int            m_len;
    bit            m_held;
    int            m_hidx;
    int            m_rep;
    logic [COLS-1:0] e_col;
    logic [3:0]    e_code;
    logic          e_ready;
    logic          e_multi;
    logic          e_over;

    task automatic model_clear_history();
        m_mask = '0;
        m_prev = NONE;
        m_len  = 0;
        m_held = 1'b0;
        m_rep  = 0;
    endtask

    task automatic model_eval(input bit rdy_now);
        int  n;
        int  cand;
        bit  acc;
        n = $countones(m_mask);
        cand = NONE;
        if (n >= 2) begin
            e_multi = 1'b1;
            cand = INV;
            m_len = 0;
        end else begin
            for (int i = 0; i < NK; i++)
                if (m_mask[i]) cand = i;
            if (cand == m_prev)
                m_len = (m_len >= DF) ? DF : m_len + 1;
            else
                m_len = 1;
        end
        acc = (cand >= 0) && (m_len == DF) && !m_held;
        if (cand == NONE && m_len == DF)
            m_held = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        if (m_held && cand >= 0 && cand == m_hidx) begin
            m_rep++;
            if (m_rep == RF) begin
                m_rep = 0;
                acc = 1'b1;
            end
        end else begin
            m_rep = 0;
        end
`endif
        if (acc) begin
            m_held = 1'b1;
            m_hidx = cand;
            if (rdy_now) begin
                e_over = 1'b1;
            end else begin
                e_ready = 1'b1;
                e_code  = 4'(cand);
            end
        end
        m_prev = cand;
    endtask

    task automatic model_step();
        bit rdy_now;
        int k;
        if (!rst_n) begin
            m_run = 1'b0;
            m_pos = 0;
            model_clear_history();
            e_col = '0; e_code = '0; e_ready = 1'b0; e_multi = 1'b0; e_over = 1'b0;
            return;
        end
        rdy_now = e_ready;
        e_multi = 1'b0;
        e_over  = 1'b0;
        if (e_ready && key_ack)
            e_ready = 1'b0;
        if (!m_run) begin
            if (scan) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos < COLS * PER) begin
            if (m_pos % PER == PER - 1) begin
                if (!scan) begin
                    m_run = 1'b0;
                    model_clear_history();
                end else begin
                    k = m_pos / PER;
                    for (int rt = 0; rt < ROWS; rt++)
                        m_mask[rt * COLS + k] = keys[rt * COLS + k];
                    m_pos++;
                end
            end else begin
                m_pos++;
            end
        end else begin
            model_eval(rdy_now);
            if (scan) m_pos = 0;
            else m_run = 1'b0;
        end
        e_col = (m_run && m_pos < COLS * PER) ? COLS'(1 << (COLS - 1 - m_pos / PER)) : '0;
    endtask

    always begin
        @(posedge clk);
        model_step();
        #2;
        check("col", 32'(col), 32'(e_col));
        check("key_code", 32'(key_code), 32'(e_code));
        check("key_ready", 32'(key_ready), 32'(e_ready));
        check("multi_key", 32'(multi_key), 32'(e_multi));
        check("overrun", 32'(overrun), 32'(e_over));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ack_once();
        @(negedge clk); key_ack = 1'b1;
        @(negedge clk); key_ack = 1'b0;
    endtask

    int pulses;
    int reports;
    int a;
    int b;
    int sel;

    initial begin
        rst_n = 1'b0; scan = 1'b0; keys = '0; key_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step(5);
        check("idle_col", 32'(col), 32'h0);
        check("idle_ready", 32'(key_ready), 32'h0);
        check("idle_code", 32'(key_code), 32'h0);

        @(negedge clk); keys = 12'd1; scan = 1'b1;
        step(1);  check("strobe_c2", 32'(col), 32'h4);
        step(10); check("strobe_c1", 32'(col), 32'h2);
        step(10); check("strobe_c0", 32'(col), 32'h1);
        step(10); check("eval_col", 32'(col), 32'h0);
        step(1);  check("frame2_c2", 32'(col), 32'h4);
        step(30); check("ready_early", 32'(key_ready), 32'h0);
        step(1);  check("ready_key0", 32'(key_ready), 32'h1);
        check("code_key0", 32'(key_code), 32'h0);
        ack_once();
        step(1);  check("ack_clears", 32'(key_ready), 32'h0);

`ifdef KEYPAD_REPEAT_EN
        @(negedge clk); keys = '0;
        step(4 * FRAME);
        @(negedge clk); keys = 12'd1 << 5;
        reports = 0;
        repeat (12 * FRAME) begin
            @(posedge clk); #2;
            if (key_ready) begin
                reports++;
                ack_once();
            end
        end
        check("repeat_reports", 32'(reports >= 3), 32'h1);
`else
        step(5 * FRAME);
        check("no_second_report", 32'(key_ready), 32'h0);
`endif

        @(negedge clk); keys = '0;
        step(4 * FRAME);
        @(negedge clk); keys = 12'd1 << 11;
        step(4 * FRAME);
        check("ready_key11", 32'(key_ready), 32'h1);
        check("code_key11", 32'(key_code), 32'hb);
        ack_once();

        @(negedge clk); keys = '0;
        step(3 * FRAME);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); keys = (i % 2 == 0) ? (12'd1 << 7) : '0;
            repeat (FRAME - 1) @(negedge clk);
        end
        @(negedge clk); keys = '0;
        step(1);
        check("bounce_no_ready", 32'(key_ready), 32'h0);

        @(negedge clk); keys = (12'd1 << 1) | (12'd1 << 6);
        step(2 * FRAME);
        pulses = 0;
        repeat (4 * FRAME) begin
            @(posedge clk); #2;
            if (multi_key) pulses++;
        end
        check("multi_pulses", 32'(pulses), 32'd4);
        check("multi_no_ready", 32'(key_ready), 32'h0);

        @(negedge clk); keys = '0;
        step(3 * FRAME);
        @(negedge clk); keys = 12'd1 << 4;
        step(4 * FRAME);
        check("ready_key4", 32'(key_ready), 32'h1);
        check("code_key4", 32'(key_code), 32'h4);
        @(negedge clk); keys = '0;
        step(4 * FRAME);
        @(negedge clk); keys = 12'd1 << 8;
        pulses = 0;
        repeat (5 * FRAME) begin
            @(posedge clk); #2;
            if (overrun) pulses++;
        end
`ifndef KEYPAD_REPEAT_EN
        check("overrun_once", 32'(pulses), 32'd1);
`endif
        check("overrun_keeps_code", 32'(key_code), 32'h4);
        check("overrun_keeps_ready", 32'(key_ready), 32'h1);
        ack_once();

        @(negedge clk); keys = '0;
        step(4 * FRAME);
        @(negedge clk); keys = 12'd1 << 2;
        step(4 * FRAME);
        check("code_key2", 32'(key_code), 32'h2);
        for (int i = 0; i < 100 && col != 3'b100; i++) step(1);
        for (int i = 0; i < 100 && col != 3'b010; i++) step(1);
        check("sync_col1", 32'(col), 32'h2);
        @(negedge clk); scan = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("stop_col1_held", 32'(col), 32'h2);
        step(1);  check("stop_col_off", 32'(col), 32'h0);
        step(25); check("stop_idle", 32'(col), 32'h0);
        check("stop_keeps_ready", 32'(key_ready), 32'h1);
        check("stop_keeps_code", 32'(key_code), 32'h2);

        @(negedge clk); scan = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        step(1);
        check("rst_col", 32'(col), 32'h0);
        check("rst_ready", 32'(key_ready), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        @(negedge clk); rst_n = 1'b1; keys = '0;

        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            sel = $urandom_range(0, 9);
            a = $urandom_range(0, NK - 1);
            b = $urandom_range(0, NK - 1);
            if (sel < 4) keys = '0;
            else if (sel < 8) keys = 12'd1 << a;
            else keys = (12'd1 << a) | (12'd1 << b);
            scan = ($urandom_range(0, 15) != 0);
            rst_n = ($urandom_range(0, 39) != 0);
            repeat ($urandom_range(20, 160)) begin
                @(negedge clk);
                rst_n = 1'b1;
                key_ack = ($urandom_range(0, 7) == 0);
            end
        end
        key_ack = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
